// File: rtl/pe_row.sv
// pe_row: linear row of N output-stationary MAC processing elements.
//
// Activations enter PE0 from the left and shift one PE per cycle together
// with a valid bit. Each PE registers its own weight from the top edge every
// cycle and passes it downward on wgt_out. On every edge where a PE holds a
// valid activation it accumulates act*wgt (signed or unsigned, wrapping or
// saturating). A drain request copies all accumulators into a shadow bank in
// one edge. The shadow bank is then serialised on sum_out, one PE per beat.
// The accumulators keep running while the readout is in progress.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   en              global enable; 0 freezes every register
//   in_valid/act_in activation entering PE0
//   wgt_in          weight for PE i on bits [i*DW +: DW] (caller skews)
//   clear           zero all accumulators (wins over a same-cycle MAC)
//   drain           request snapshot + readout (ignored while busy)
//   act_out/act_valid_out  activation and valid leaving PE N-1
//   wgt_out         registered weights, PE i on bits [i*DW +: DW]
//   sum_out/sum_valid/sum_idx  registered readout beat
//   busy            readout in progress
module pe_row #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int AW     = 36,
  parameter int SIGNED = 1,
  parameter int SAT    = 0,
  localparam int IW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [DW-1:0]   act_in,
  input  logic [N*DW-1:0] wgt_in,
  input  logic            clear,
  input  logic            drain,
  output logic [DW-1:0]   act_out,
  output logic            act_valid_out,
  output logic [N*DW-1:0] wgt_out,
  output logic [AW-1:0]   sum_out,
  output logic            sum_valid,
  output logic [IW-1:0]   sum_idx,
  output logic            busy
);

  localparam logic SGN = (SIGNED != 0);
  localparam logic SAT_EN = (SAT != 0);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   a_q [N];
  logic [DW-1:0]   a_d [N];
  logic [DW-1:0]   w_q [N];
  logic [DW-1:0]   w_d [N];
  logic [N-1:0]    v_q, v_d;
  logic [AW-1:0]   acc_q [N];
  logic [AW-1:0]   acc_d [N];
  logic [AW-1:0]   shadow_q [N];
  logic [AW-1:0]   shadow_d [N];

  logic [2*DW-1:0] prod_raw [N];
  logic [AW-1:0]   prod_ext [N];
  logic [AW:0]     sum_x [N];
  logic [AW-1:0]   mac_sum [N];

  logic [AW-1:0]   sum_out_q, sum_out_d;
  logic            sum_valid_q, sum_valid_d;
  logic [IW-1:0]   sum_idx_q, sum_idx_d;

  logic            drain_go;

  // A drain is only taken from IDLE; requests during readout are dropped.
  assign drain_go = en && drain && (state_q == S_IDLE);

  // Product and accumulate-with-overflow-handling, one per PE.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      // Operands extended to 2*DW first, so the 2*DW-bit product is exact
      // for both signed and unsigned interpretation.
      prod_raw[i] = {{DW{a_q[i][DW-1] & SGN}}, a_q[i]} *
                    {{DW{w_q[i][DW-1] & SGN}}, w_q[i]};
      if (SGN) begin
        prod_ext[i] = AW'($signed(prod_raw[i]));
        sum_x[i]    = {acc_q[i][AW-1], acc_q[i]} + {prod_ext[i][AW-1], prod_ext[i]};
        // Guard bit disagreeing with the AW sign bit means the true sum left
        // the signed range; the guard bit holds the true sign.
        if (SAT_EN && (sum_x[i][AW] != sum_x[i][AW-1])) begin
          mac_sum[i] = sum_x[i][AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
          mac_sum[i] = sum_x[i][AW-1:0];
        end
      end else begin
        prod_ext[i] = AW'(prod_raw[i]);
        sum_x[i]    = {1'b0, acc_q[i]} + {1'b0, prod_ext[i]};
        if (SAT_EN && sum_x[i][AW]) begin
          mac_sum[i] = '1;
        end else begin
          mac_sum[i] = sum_x[i][AW-1:0];
        end
      end
    end
  end

  // Datapath next state: pipeline shift, weights, accumulators, shadow bank.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    a_d      = a_q;
    v_d      = v_q;
    w_d      = w_q;
    acc_d    = acc_q;
    shadow_d = shadow_q;
    if (en) begin
      a_d[0] = act_in;
      v_d[0] = in_valid;
      for (int i = 1; i < N; i++) begin
        a_d[i] = a_q[i-1];
        v_d[i] = v_q[i-1];
      end
      for (int i = 0; i < N; i++) begin
        w_d[i] = wgt_in[i*DW +: DW];
        if (clear) begin
          acc_d[i] = '0;
        end else if (drain_go) begin
          // The old total moves to the shadow bank; this cycle's product
          // starts the next total.
          acc_d[i] = v_q[i] ? prod_ext[i] : '0;
        end else if (v_q[i]) begin
          acc_d[i] = mac_sum[i];
        end
      end
      if (drain_go) begin
        shadow_d = acc_q;
      end
    end
  end

  // Drain FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drain FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (drain) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
        S_DRAIN: begin
          if (cnt_q == IW'(N - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Drain FSM: outputs, registered one edge behind the state.
  always_comb begin
    sum_out_d   = sum_out_q;
    sum_valid_d = sum_valid_q;
    sum_idx_d   = sum_idx_q;
    if (en) begin
      if (state_q == S_DRAIN) begin
        sum_out_d   = shadow_q[cnt_q];
        sum_valid_d = 1'b1;
        sum_idx_d   = cnt_q;
      end else begin
        sum_out_d   = '0;
        sum_valid_d = 1'b0;
        sum_idx_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow bank is a register array read straight onto
      // sum_out, so it is reset with everything else rather than left
      // uninitialised like a RAM.
      for (int i = 0; i < N; i++) begin
        a_q[i]      <= '0;
        w_q[i]      <= '0;
        acc_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
      v_q         <= '0;
      sum_out_q   <= '0;
      sum_valid_q <= 1'b0;
      sum_idx_q   <= '0;
    end else begin
      a_q         <= a_d;
      w_q         <= w_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      shadow_q    <= shadow_d;
      sum_out_q   <= sum_out_d;
      sum_valid_q <= sum_valid_d;
      sum_idx_q   <= sum_idx_d;
    end
  end

  assign act_out       = a_q[N-1];
  assign act_valid_out = v_q[N-1];
  assign sum_out       = sum_out_q;
  assign sum_valid     = sum_valid_q;
  assign sum_idx       = sum_idx_q;
  assign busy          = (state_q == S_DRAIN);

  for (genvar g = 0; g < N; g++) begin : g_wgt_out
    assign wgt_out[g*DW +: DW] = w_q[g];
  end

endmodule

// File: tb/tb_pe_row.sv
// Bench for pe_row: three instances sharing one stimulus stream
//   d0: AW=36 signed wrapping, d1: AW=32 signed saturating,
//   d2: AW=32 unsigned saturating.
// A history-based model (input log indexed by enabled edge, arithmetic on
// longint) predicts every output on every cycle; directed steps add checks
// against hand-computed constants.
module tb_pe_row;
  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic            in_valid;
  logic [DW-1:0]   act_in;
  logic [N*DW-1:0] wgt_in;
  logic            clear;
  logic            drain;

  logic [DW-1:0]   d0_act_out, d1_act_out, d2_act_out;
  logic            d0_act_valid_out, d1_act_valid_out, d2_act_valid_out;
  logic [N*DW-1:0] d0_wgt_out, d1_wgt_out, d2_wgt_out;
  logic [35:0]     d0_sum_out;
  logic [31:0]     d1_sum_out, d2_sum_out;
  logic            d0_sum_valid, d1_sum_valid, d2_sum_valid;
  logic [1:0]      d0_sum_idx, d1_sum_idx, d2_sum_idx;
  logic            d0_busy, d1_busy, d2_busy;

  pe_row #(.N(N), .DW(DW), .AW(36), .SIGNED(1), .SAT(0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .act_in(act_in),
    .wgt_in(wgt_in), .clear(clear), .drain(drain), .act_out(d0_act_out),
    .act_valid_out(d0_act_valid_out), .wgt_out(d0_wgt_out), .sum_out(d0_sum_out),
    .sum_valid(d0_sum_valid), .sum_idx(d0_sum_idx), .busy(d0_busy));

  pe_row #(.N(N), .DW(DW), .AW(32), .SIGNED(1), .SAT(1)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .act_in(act_in),
    .wgt_in(wgt_in), .clear(clear), .drain(drain), .act_out(d1_act_out),
    .act_valid_out(d1_act_valid_out), .wgt_out(d1_wgt_out), .sum_out(d1_sum_out),
    .sum_valid(d1_sum_valid), .sum_idx(d1_sum_idx), .busy(d1_busy));

  pe_row #(.N(N), .DW(DW), .AW(32), .SIGNED(0), .SAT(1)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .act_in(act_in),
    .wgt_in(wgt_in), .clear(clear), .drain(drain), .act_out(d2_act_out),
    .act_valid_out(d2_act_valid_out), .wgt_out(d2_wgt_out), .sum_out(d2_sum_out),
    .sum_valid(d2_sum_valid), .sum_idx(d2_sum_idx), .busy(d2_busy));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: input log per enabled edge, accumulator and snapshot values.
  logic [DW-1:0]   act_h [8192];
  bit              val_h [8192];
  logic [N*DW-1:0] wgt_h [8192];
  int              ecnt;
  int              last_acc;
  longint          m_acc  [3][N];
  longint          m_snap [3][N];

  logic [63:0]     exp_v [3][N];

  function automatic int cfg_aw(int k);
    return (k == 0) ? 36 : 32;
  endfunction
  function automatic bit cfg_sgn(int k);
    return (k != 2);
  endfunction
  function automatic bit cfg_sat(int k);
    return (k != 0);
  endfunction

  function automatic logic [63:0] dut_sum(int k);
    case (k)
      0:       return 64'(d0_sum_out);
      1:       return 64'(d1_sum_out);
      default: return 64'(d2_sum_out);
    endcase
  endfunction
  function automatic logic [63:0] dut_sv(int k);
    case (k)
      0:       return 64'(d0_sum_valid);
      1:       return 64'(d1_sum_valid);
      default: return 64'(d2_sum_valid);
    endcase
  endfunction
  function automatic logic [63:0] dut_idx(int k);
    case (k)
      0:       return 64'(d0_sum_idx);
      1:       return 64'(d1_sum_idx);
      default: return 64'(d2_sum_idx);
    endcase
  endfunction
  function automatic logic [63:0] dut_busy(int k);
    case (k)
      0:       return 64'(d0_busy);
      1:       return 64'(d1_busy);
      default: return 64'(d2_busy);
    endcase
  endfunction

  function automatic longint prod(logic [DW-1:0] a, logic [DW-1:0] w, bit sgn);
    if (sgn) return longint'($signed(a)) * longint'($signed(w));
    return longint'(a) * longint'(w);
  endfunction

  // True-valued add, then wrap or clamp into the AW-bit range.
  function automatic longint accum(longint acc, longint p, int aw, bit sgn, bit sat);
    longint s    = acc + p;
    longint span = longint'(1) <<< aw;
    longint hi, lo;
    if (sgn) begin
      hi = (span >>> 1) - 1;
      lo = -(span >>> 1);
    end else begin
      hi = span - 1;
      lo = 0;
    end
    if (s > hi)      s = sat ? hi : s - span;
    else if (s < lo) s = sat ? lo : s + span;
    return s;
  endfunction

  function automatic logic [63:0] pat(longint v, int aw);
    longint m = (longint'(1) <<< aw) - 1;
    return 64'(v & m);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    ecnt     = 0;
    last_acc = -1000;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        m_acc[k][i]  = 0;
        m_snap[k][i] = 0;
      end
    end
  endtask

  // One enabled edge: PE i at edge e multiplies the activation that entered
  // at edge e-1-i with the weight row registered at edge e-1.
  task automatic model_edge();
    int          e, s;
    bit          go, vv;
    logic [DW-1:0] aa, ww;
    longint      p;
    e  = ecnt;
    go = drain && (e - last_acc > N);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) begin
        s  = e - 1 - i;
        vv = (s >= 0) ? val_h[s] : 1'b0;
        aa = (s >= 0) ? act_h[s] : '0;
        ww = (e >= 1) ? wgt_h[e-1][DW*i +: DW] : '0;
        p  = prod(aa, ww, cfg_sgn(k));
        if (go) m_snap[k][i] = m_acc[k][i];
        if (clear)      m_acc[k][i] = 0;
        else if (go)    m_acc[k][i] = vv ? p : 0;
        else if (vv)    m_acc[k][i] = accum(m_acc[k][i], p, cfg_aw(k), cfg_sgn(k), cfg_sat(k));
      end
    end
    if (go) last_acc = e;
    act_h[e] = act_in;
    val_h[e] = in_valid;
    wgt_h[e] = wgt_in;
    ecnt     = e + 1;
  endtask

  // Compare every output with the model after the most recent enabled edge.
  task automatic check_all();
    int e, d, src;
    bit bv, bz;
    e   = ecnt - 1;
    d   = e - last_acc;
    src = e - (N - 1);
    check("act_out", 64'(d0_act_out), (src >= 0) ? 64'(act_h[src]) : 64'd0);
    check("act_valid_out", 64'(d0_act_valid_out), (src >= 0) ? 64'(val_h[src]) : 64'd0);
    check("wgt_out", 64'(d0_wgt_out), (e >= 0) ? 64'(wgt_h[e]) : 64'd0);
    bv = (d >= 1) && (d <= N);
    bz = (d >= 0) && (d <= N - 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("sum_valid[d%0d]", k), dut_sv(k), 64'(bv));
      check($sformatf("sum_idx[d%0d]", k), dut_idx(k), bv ? 64'(d - 1) : 64'd0);
      check($sformatf("sum_out[d%0d]", k), dut_sum(k),
            bv ? pat(m_snap[k][d-1], cfg_aw(k)) : 64'd0);
      check($sformatf("busy[d%0d]", k), dut_busy(k), 64'(bz));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n && en) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_exp(input int k, input logic [63:0] v0, v1, v2, v3);
    exp_v[k][0] = v0;
    exp_v[k][1] = v1;
    exp_v[k][2] = v2;
    exp_v[k][3] = v3;
  endtask

  task automatic set_exp_all(input logic [63:0] v0, v1, v2, v3);
    for (int k = 0; k < 3; k++) set_exp(k, v0, v1, v2, v3);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    act_in   = '0;
    wgt_in   = '0;
    clear    = 1'b0;
    drain    = 1'b0;
  endtask

  task automatic flush();
    idle_inputs();
    repeat (N + 2) cycle();
    clear = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  // Pulse drain, then watch a window wide enough to expose extra beats.
  task automatic drain_read(input bit repulse);
    int beats = 0;
    drain = 1'b1;
    cycle();
    drain = 1'b0;
    for (int w = 0; w < 2 * N + 4; w++) begin
      if (d0_sum_valid) begin
        if (beats < N) begin
          check("beat_idx", 64'(d0_sum_idx), 64'(beats));
          for (int k = 0; k < 3; k++)
            check($sformatf("beat_val[d%0d]", k), dut_sum(k), exp_v[k][beats]);
        end
        beats++;
      end
      drain = repulse && (beats == 1);
      cycle();
    end
    drain = 1'b0;
    check("beat_count", 64'(beats), 64'(N));
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;

    // Reset held over three clocks with random inputs.
    repeat (3) begin
      in_valid = 1'($urandom_range(0, 1));
      act_in   = DW'($urandom);
      wgt_in   = {$urandom, $urandom};
      clear    = 1'($urandom_range(0, 1));
      drain    = 1'($urandom_range(0, 1));
      cycle();
    end
    check("rst_sum_valid", 64'(d0_sum_valid), 64'd0);
    check("rst_busy", 64'(d0_busy), 64'd0);
    idle_inputs();
    rst_n = 1'b1;
    cycle();

    // Single element, skewed weights 2..5.
    flush();
    for (int c = 0; c < N; c++) begin
      act_in   = (c == 0) ? DW'(3) : '0;
      in_valid = (c == 0);
      wgt_in   = '0;
      wgt_in[DW*c +: DW] = DW'(2 + c);
      cycle();
      if (c == N - 2) check("act_valid_early", 64'(d0_act_valid_out), 64'd0);
    end
    check("act_out_lat", 64'(d0_act_out), 64'd3);
    check("act_valid_lat", 64'(d0_act_valid_out), 64'd1);
    idle_inputs();
    cycle();
    check("act_valid_after", 64'(d0_act_valid_out), 64'd0);
    set_exp_all(6, 9, 12, 15);
    drain_read(1'b0);

    // Four-element accumulation with unit weights, then clear.
    flush();
    wgt_in = {N{DW'(1)}};
    for (int a = 1; a <= 4; a++) begin
      act_in   = DW'(a);
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    act_in   = '0;
    repeat (N + 1) cycle();
    set_exp_all(10, 10, 10, 10);
    drain_read(1'b0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    set_exp_all(0, 0, 0, 0);
    drain_read(1'b0);

    // Signed vs unsigned: 0xFFFE * 3 at PE0.
    flush();
    act_in = 16'hFFFE; wgt_in = 64'h3; in_valid = 1'b1;
    cycle();
    idle_inputs();
    repeat (N + 1) cycle();
    set_exp(0, 64'hF_FFFF_FFFA, 0, 0, 0);
    set_exp(1, 64'hFFFF_FFFA, 0, 0, 0);
    set_exp(2, 64'h2_FFFA, 0, 0, 0);
    drain_read(1'b0);

    // -32768 * -32768 twice: wraps past 2^31 at AW=32, clamps when saturating.
    flush();
    act_in = 16'h8000; wgt_in = 64'h8000; in_valid = 1'b1;
    repeat (2) cycle();
    idle_inputs();
    repeat (N + 1) cycle();
    set_exp(0, 64'h8000_0000, 0, 0, 0);
    set_exp(1, 64'h7FFF_FFFF, 0, 0, 0);
    set_exp(2, 64'h8000_0000, 0, 0, 0);
    drain_read(1'b0);

    // -32768 * 32767 three times: negative clamp at AW=32 signed.
    flush();
    act_in = 16'h8000; wgt_in = 64'h7FFF; in_valid = 1'b1;
    repeat (3) cycle();
    idle_inputs();
    repeat (N + 1) cycle();
    set_exp(0, 64'hF_4001_8000, 0, 0, 0);
    set_exp(1, 64'h8000_0000, 0, 0, 0);
    set_exp(2, 64'hBFFE_8000, 0, 0, 0);
    drain_read(1'b0);

    // 0xFFFF * 0xFFFF twice: unsigned overflow clamps to all ones.
    flush();
    act_in = 16'hFFFF; wgt_in = 64'hFFFF; in_valid = 1'b1;
    repeat (2) cycle();
    idle_inputs();
    repeat (N + 1) cycle();
    set_exp(0, 64'd2, 0, 0, 0);
    set_exp(1, 64'd2, 0, 0, 0);
    set_exp(2, 64'hFFFF_FFFF, 0, 0, 0);
    drain_read(1'b0);

    // Overlap: drain on the edge of a 2x2 MAC at PE0 holding 10; re-pulse
    // while busy; the next drain shows 4.
    flush();
    act_in = 16'd5; wgt_in = 64'h2; in_valid = 1'b1;
    cycle();
    idle_inputs();
    repeat (N + 1) cycle();
    act_in = 16'd2; wgt_in = 64'h2; in_valid = 1'b1;
    cycle();
    idle_inputs();
    set_exp_all(10, 0, 0, 0);
    drain_read(1'b1);
    set_exp_all(4, 0, 0, 0);
    drain_read(1'b0);

    // Enable low mid-drain freezes everything, including the readout.
    drain = 1'b1;
    cycle();
    drain = 1'b0;
    repeat (2) cycle();
    en = 1'b0;
    repeat (4) begin
      in_valid = 1'($urandom_range(0, 1));
      act_in   = DW'($urandom);
      wgt_in   = {$urandom, $urandom};
      clear    = 1'($urandom_range(0, 1));
      drain    = 1'($urandom_range(0, 1));
      cycle();
    end
    en = 1'b1;
    idle_inputs();
    repeat (N + 3) cycle();

    // Asynchronous reset in the middle of a readout.
    drain = 1'b1;
    cycle();
    drain = 1'b0;
    repeat (2) cycle();
    check("pre_rst_busy", 64'(d0_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("async_busy[d%0d]", k), dut_busy(k), 64'd0);
      check($sformatf("async_sum_valid[d%0d]", k), dut_sv(k), 64'd0);
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Random traffic against the model.
    repeat (600) begin
      en       = ($urandom_range(0, 9) != 0);
      in_valid = 1'($urandom_range(0, 1));
      act_in   = DW'($urandom);
      wgt_in   = {$urandom, $urandom};
      clear    = ($urandom_range(0, 39) == 0);
      drain    = ($urandom_range(0, 7) == 0);
      cycle();
    end
    en = 1'b1;
    idle_inputs();
    repeat (2 * N + 2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_row.md
Name: pe_row

Overview:
- Parametrised successor to the single output-stationary PE: a linear row of N MAC processing elements.
- Activations enter at the left edge and shift one PE per cycle, carrying a valid bit. Each PE takes its own weight stream from the top edge.
- Each PE accumulates a signed or unsigned product with optional saturation.
- A drain FSM snapshots all accumulators into a shadow bank and serialises them on one output port, so computation can continue while results are read. The block is the row tile of the attention systolic array.

Parameters:
- N, 4, number of PEs in the row (≥1)
- DW, 16, activation/weight width
- AW, 36, accumulator width (≥2*DW)
- SIGNED, 1, 1 = two's-complement multiply, 0 = unsigned
- SAT, 0, 1 = accumulator saturates at min/max of AW, 0 = wraps modulo 2^AW

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en  in  1  global enable; 0 freezes every register including the FSM
- in_valid  in  1  act_in is valid
- act_in  in  DW  activation into PE0
- wgt_in  in  N*DW  weight for PE i on bits [i*DW +: DW]
- clear  in  1  zero all accumulators
- drain  in  1  request snapshot and readout
- act_out  out  DW  activation leaving PE N-1
- act_valid_out  out  1  valid leaving PE N-1
- wgt_out  out  N*DW  registered weights passed downward
- sum_out  out  AW  serialised accumulator value
- sum_valid  out  1  sum_out is valid
- sum_idx  out  clog2(N) (min 1)  PE index of sum_out
- busy  out  1  drain in progress; drain is not accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset clears every register. All outputs, accumulators, the shadow bank and the FSM (IDLE) go to 0 immediately on rst_n low, including mid-drain.
- en=0: no register changes and outputs hold. All rules below apply only when en=1.
- Pipeline registers, per PE i: a_r[i], v_r[i], w_r[i].
  - a_r[0]<=act_in and v_r[0]<=in_valid.
  - For i>0: a_r[i]<=a_r[i-1] and v_r[i]<=v_r[i-1].
  - w_r[i]<=wgt_in slice i, every cycle.
  - act_out=a_r[N-1], act_valid_out=v_r[N-1], wgt_out=concatenation of w_r.
- Weight alignment: the caller skews weights. The weight for stream element k at PE i is presented in the same cycle that element k would be presented at act_in plus i cycles.
- MAC: at each edge where v_r[i]=1, acc[i] <= acc[i] + ext(a_r[i]*w_r[i]).
  - The product is 2*DW bits, sign- or zero-extended to AW per SIGNED.
  - Latency: a sample presented at edge t is in acc[0] after edge t+1, and in acc[i] after edge t+1+i.
  - Overflow with SAT=1: positive overflow clamps to 2^(AW-1)-1, negative overflow clamps to -2^(AW-1). With SIGNED=0 and SAT=1, overflow clamps to 2^AW-1.
  - Overflow with SAT=0: the sum wraps.
- clear: acc[*]<=0. clear has priority over a MAC in the same cycle, and that product is dropped.
- FSM IDLE:
  - busy=0, sum_valid=0.
  - drain=1 causes, on the same edge: shadow[*]<=acc[*]. Each acc[i] is set to that cycle's product if v_r[i]=1, otherwise 0. The state goes to DRAIN with cnt=0.
  - drain together with clear: the snapshot takes the pre-clear values, and acc goes to 0 (the product is dropped).
- FSM DRAIN:
  - busy=1, sum_valid=1, sum_out=shadow[cnt], sum_idx=cnt.
  - cnt increments each edge. After cnt=N-1 the state returns to IDLE, so exactly N consecutive valid beats are produced.
  - drain is ignored while in DRAIN.
  - MAC and clear keep operating on acc normally. The shadow bank is unaffected.
- Output registering: sum_out, sum_valid and sum_idx are registered, so the first beat appears on the edge after drain is accepted.
- N=1: DRAIN lasts a single beat.

Test Plan:
- Reset: hold rst_n=0 over 3 clocks with random inputs -> every output is 0. Assert rst_n low mid-DRAIN -> sum_valid and busy drop to 0 without waiting for a clock edge.
- Single element (N=4, SIGNED=1): act_in=3 valid for one cycle, weights 2,3,4,5 skewed to PE0..3, then drain -> 4 beats with sum_idx 0..3 and sum_out 6, 9, 12, 15. act_out=3 with act_valid_out=1 is seen exactly 4 edges after input.
- Four-element accumulation: acts 1,2,3,4 on consecutive cycles with all weights 1 -> every sum is 10. Follow with clear, then drain -> all sums are 0.
- Signed arithmetic: act=0xFFFE (-2), w=0x0003 -> sum_out = -6 (0xFFFFFFFFA at AW=36). With SIGNED=0 the same inputs give 0x2FFFA.
- Saturation (AW=32, SAT=1): -32768 × -32768 accumulated twice at PE0 -> sum_out 0x7FFFFFFF. With SAT=0 the result is 0x80000000.
- Overlap: drain in the same cycle as a valid MAC of 2×2 at PE0 holding 10.
  - Readout gives 10.
  - acc[0] then holds 4, confirmed by a second drain.
  - A drain pulsed while busy=1 produces no extra beats.
